// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals shared by the two-client SRAM arbiter.
// The arbiter uses the slave modport; the requesters and the SRAM model use master.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              resp0, resp1;
  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_resp;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata, sram_resp,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, resp0, resp1,
           sram_cs, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata, sram_resp,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, resp0, resp1,
           sram_cs, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// One command in flight at a time; every output comes straight from a flop.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic                aclk,
  input logic                areset,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t                  state_q, state_d;
  logic                    prio_q, prio_d;
  logic                    winner_q, winner_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              resp_q, resp_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;

  // Outputs are registered, so each is computed for the state being entered.
  // The SRAM command registers double as the latched command and hold through WAIT.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    resp_d   = '0;
    rdata_d  = '0;
    cs_d     = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_d        = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          gnt_d[winner_d] = 1'b1;
          cs_d            = 1'b1;
          we_d            = winner_d ? bus.we1    : bus.we0;
          addr_d          = winner_d ? bus.addr1  : bus.addr0;
          wdata_d         = winner_d ? bus.wdata1 : bus.wdata0;
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        prio_d  = ~winner_q;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          done_d[winner_q]  = 1'b1;
          resp_d[winner_q]  = bus.sram_resp;
          rdata_d[winner_q] = we_q ? '0 : bus.sram_rdata;
          state_d           = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.gnt0       = gnt_q[0];
  assign bus.gnt1       = gnt_q[1];
  assign bus.done0      = done_q[0];
  assign bus.done1      = done_q[1];
  assign bus.resp0      = resp_q[0];
  assign bus.resp1      = resp_q[1];
  assign bus.rdata0     = rdata_q[0];
  assign bus.rdata1     = rdata_q[1];
  assign bus.sram_cs    = cs_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one DUT at RD_LAT=1 and one at RD_LAT=3,
// sharing clock and reset, with hand-computed expectations at each step.
module tb_sram_port_arbiter;
  logic aclk;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    areset = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.sram_rdata = 0; bus.sram_resp = 0;
    bus3.req0 = 0; bus3.req1 = 0; bus3.we0 = 0; bus3.we1 = 0;
    bus3.addr0 = 0; bus3.addr1 = 0; bus3.wdata0 = 0; bus3.wdata1 = 0;
    bus3.sram_rdata = 0; bus3.sram_resp = 0;

    applyStimulus(2);
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    checkOutput("rst_done0", bus.done0, 0);
    checkOutput("rst_done1", bus.done1, 0);
    checkOutput("rst_cs", bus.sram_cs, 0);
    checkOutput("rst_addr", bus.sram_addr, 0);
    areset = 1'b0;

    // Single write from requester 0
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF; bus.sram_resp = 1;
    applyStimulus(1);
    checkOutput("wr_gnt0", bus.gnt0, 1);
    checkOutput("wr_gnt1", bus.gnt1, 0);
    checkOutput("wr_cs", bus.sram_cs, 1);
    checkOutput("wr_we", bus.sram_we, 1);
    checkOutput("wr_addr", bus.sram_addr, 32'h10);
    checkOutput("wr_wdata", bus.sram_wdata, 32'hDEADBEEF);
    bus.req0 = 0; bus.wdata0 = 0;
    applyStimulus(1);
    checkOutput("wr_wait_cs", bus.sram_cs, 0);
    checkOutput("wr_wait_gnt0", bus.gnt0, 0);
    checkOutput("wr_wait_addr_hold", bus.sram_addr, 32'h10);
    checkOutput("wr_wait_done0", bus.done0, 0);
    applyStimulus(1);
    checkOutput("wr_done0", bus.done0, 1);
    checkOutput("wr_resp0", bus.resp0, 1);
    checkOutput("wr_rdata0", bus.rdata0, 0);
    checkOutput("wr_done1", bus.done1, 0);
    applyStimulus(1);
    checkOutput("wr_done0_pulse", bus.done0, 0);

    // Read-back through requester 1
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h10; bus.sram_rdata = 32'hDEADBEEF;
    applyStimulus(1);
    checkOutput("rd_gnt1", bus.gnt1, 1);
    checkOutput("rd_gnt0", bus.gnt0, 0);
    checkOutput("rd_cs", bus.sram_cs, 1);
    checkOutput("rd_we", bus.sram_we, 0);
    checkOutput("rd_addr", bus.sram_addr, 32'h10);
    bus.req1 = 0;
    applyStimulus(2);
    checkOutput("rd_done1", bus.done1, 1);
    checkOutput("rd_rdata1", bus.rdata1, 32'hDEADBEEF);
    checkOutput("rd_resp1", bus.resp1, 1);
    checkOutput("rd_done0", bus.done0, 0);
    checkOutput("rd_rdata0", bus.rdata0, 0);
    applyStimulus(1);
    checkOutput("rd_done1_pulse", bus.done1, 0);

    // Error response passes through, next transaction is normal
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h20; bus.sram_rdata = 32'h12345678; bus.sram_resp = 0;
    applyStimulus(1);
    checkOutput("err_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    applyStimulus(2);
    checkOutput("err_done0", bus.done0, 1);
    checkOutput("err_resp0", bus.resp0, 0);
    checkOutput("err_rdata0", bus.rdata0, 32'h12345678);
    applyStimulus(1);
    bus.req0 = 1; bus.addr0 = 32'h24; bus.sram_rdata = 32'hCAFEF00D; bus.sram_resp = 1;
    applyStimulus(1);
    checkOutput("ok_gnt0", bus.gnt0, 1);
    checkOutput("ok_addr", bus.sram_addr, 32'h24);
    bus.req0 = 0;
    applyStimulus(2);
    checkOutput("ok_done0", bus.done0, 1);
    checkOutput("ok_resp0", bus.resp0, 1);
    checkOutput("ok_rdata0", bus.rdata0, 32'hCAFEF00D);
    applyStimulus(1);

    // Contention: both held high from reset, grants alternate every 4 cycles
    areset = 1'b1;
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
    applyStimulus(2);
    checkOutput("cont_rst_gnt0", bus.gnt0, 0);
    areset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("cont_gnt0_%0d", k), bus.gnt0, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont_gnt1_%0d", k), bus.gnt1, (k % 2 == 1) ? 1 : 0);
      applyStimulus(2);
      checkOutput($sformatf("cont_done0_%0d", k), bus.done0, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont_done1_%0d", k), bus.done1, (k % 2 == 1) ? 1 : 0);
      applyStimulus(1);
    end

    // Reset during WAIT drops the transaction and restores priority to 0
    applyStimulus(1);
    checkOutput("mid_gnt0", bus.gnt0, 1);
    applyStimulus(1);
    areset = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_done0", bus.done0, 0);
    checkOutput("mid_rst_done1", bus.done1, 0);
    checkOutput("mid_rst_gnt0", bus.gnt0, 0);
    checkOutput("mid_rst_cs", bus.sram_cs, 0);
    checkOutput("mid_rst_we", bus.sram_we, 0);
    checkOutput("mid_rst_addr", bus.sram_addr, 0);
    checkOutput("mid_rst_rdata0", bus.rdata0, 0);
    areset = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_gnt0", bus.gnt0, 1);
    checkOutput("post_rst_gnt1", bus.gnt1, 0);
    checkOutput("post_rst_done0", bus.done0, 0);
    bus.req0 = 0; bus.req1 = 0;
    applyStimulus(3);

    // RD_LAT=3 read: single access cycle, capture four edges after the grant edge
    bus3.req0 = 1; bus3.we0 = 0; bus3.addr0 = 32'h40; bus3.sram_rdata = 32'h11111111; bus3.sram_resp = 1;
    applyStimulus(1);
    checkOutput("l3_gnt0", bus3.gnt0, 1);
    checkOutput("l3_cs", bus3.sram_cs, 1);
    checkOutput("l3_addr", bus3.sram_addr, 32'h40);
    bus3.req0 = 0;
    applyStimulus(1);
    checkOutput("l3_cs_n1", bus3.sram_cs, 0);
    applyStimulus(1);
    checkOutput("l3_cs_n2", bus3.sram_cs, 0);
    checkOutput("l3_done_n2", bus3.done0, 0);
    applyStimulus(1);
    checkOutput("l3_done_n3", bus3.done0, 0);
    bus3.sram_rdata = 32'hA5A5A5A5;
    applyStimulus(1);
    checkOutput("l3_done0", bus3.done0, 1);
    checkOutput("l3_rdata0", bus3.rdata0, 32'hA5A5A5A5);
    checkOutput("l3_resp0", bus3.resp0, 1);
    checkOutput("l3_cs_n4", bus3.sram_cs, 0);
    applyStimulus(1);
    checkOutput("l3_done0_pulse", bus3.done0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port SRAM (the `sram` macro behind the AXI slave interface) between a write-path client and a read-path client.
- Accepts one command at a time and drives the SRAM chip-select, write-enable, address and data for exactly one cycle.
- Waits a fixed SRAM latency, then returns read data and the SRAM response to the winning requester.
- Sits between the AXI SRAM interface front-end and the `sram` macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from the SRAM access cycle to valid sram_rdata/sram_resp; legal range 1..7.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous reset, active-high.
- req0, req1  in  1 each  request from requester 0 / 1.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W each  request address.
- wdata0, wdata1  in  DATA_W each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse: command accepted.
- done0, done1  out  1 each  one-cycle pulse: transaction complete.
- rdata0, rdata1  out  DATA_W each  read data, valid while doneN=1.
- resp0, resp1  out  1 each  SRAM response, valid while doneN=1; 1 = OK, 0 = error.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_resp  in  1  SRAM response.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state = IDLE; round-robin pointer prio = 0 (requester 0 favoured); latency counter = 0.
- FSM states: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - Samples req0/req1.
  - Only one asserted: that requester wins.
  - Both asserted: the requester indicated by prio wins.
  - Neither asserted: stay in IDLE.
  - On a win: latch winner id, we, addr and wdata into internal registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - sram_cs = 1; sram_we, sram_addr and sram_wdata come from the latched command.
  - gntW = 1 for the winner W.
  - prio <= the other requester.
  - Counter loaded with RD_LAT - 1; go to WAIT.
- WAIT:
  - sram_cs = 0; the other SRAM outputs hold their last value.
  - Counter decrements each cycle; at 0, capture sram_rdata and sram_resp, then go to RESP.
- RESP (1 cycle):
  - doneW = 1, rdataW = captured data, respW = captured response.
  - For writes, rdataW = 0.
  - The non-winning requester's done/rdata/resp stay 0.
  - Next state IDLE.
- Latency: req sampled at edge N gives gnt in cycle N+1 and done in cycle N+2+RD_LAT. With RD_LAT=1, done is in cycle N+3.
- Throughput: one transaction per RD_LAT+3 cycles.
- Requester rules:
  - Holds reqN, weN, addrN and wdataN stable until it sees gntN.
  - May drop or change them after gntN; the latched command is used.
  - Must not re-request before doneN; a request held through RESP is treated as a new request in the next IDLE.
- Deasserting req before IDLE samples it aborts cleanly: no grant, no SRAM access.
- A requester asserting req while the other is in flight waits; it is arbitrated in the next IDLE.
- sram_resp = 0 is passed through as respW = 0. There is no retry, and the FSM proceeds normally.
- Reset mid-transaction (any state):
  - Next cycle all outputs are 0, state = IDLE, prio = 0.
  - The in-flight transaction is dropped with no done pulse.
  - sram_cs is never asserted in the cycle after areset is sampled high.
- gnt0/gnt1 never both high; done0/done1 never both high; sram_cs high for exactly 1 cycle per grant.
- Counter width is 3 bits.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF, sram_resp=1 -> gnt0 in cycle N+1 with sram_cs=1, sram_we=1, sram_addr=0x10, sram_wdata=0xDEADBEEF; done0=1, resp0=1 in cycle N+3; gnt1/done1 stay 0.
- Read-back: req1 read addr1=0x10, SRAM returns 0xDEADBEEF -> gnt1 at N+1 with sram_we=0; done1 at N+3 with rdata1=0xDEADBEEF, resp1=1.
- Contention: req0 and req1 held high continuously from reset, each re-issued immediately after its done -> grants alternate 0,1,0,1 with a 4-cycle spacing; never two grants of the same requester back-to-back.
- Error path: a read with sram_resp=0 -> doneN=1 with respN=0; the next transaction completes normally with respN=1.
- Reset mid-op: assert areset during WAIT -> next cycle every output 0; no done pulse; a subsequent req1 (both asserted) is granted to requester 0 because prio is reset to 0.
- RD_LAT=3 build: read request at edge N -> sram_cs only at N+1, done at N+5 carrying the sram_rdata present at the capture edge.
